// File: rtl/wb_select_stage.sv
// Registered writeback select stage: picks one of NUM_SRC sources, applies
// load-size extraction on the memory-data source, and holds the result in a
// one-entry valid/ready stage in front of the register-file write port.
// Illegal selects and $zero writes are consumed and dropped.
module wb_select_stage #(
    parameter int DATA_W        = 32,
    parameter int NUM_SRC       = 9,
    parameter int SEL_W         = 4,
    parameter int ADDR_W        = 5,
    parameter int LOAD_SRC      = 2,
    parameter int ZERO_SUPPRESS = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC*DATA_W-1:0] src_bus,
    input  logic [SEL_W-1:0]          sel,
    input  logic [1:0]                ld_size,
    input  logic                      ld_signed,
    input  logic [ADDR_W-1:0]         dst_addr,
    input  logic                      req_valid,
    output logic                      req_ready,
    output logic                      wb_valid,
    input  logic                      wb_ready,
    output logic [DATA_W-1:0]         wb_data,
    output logic [ADDR_W-1:0]         wb_addr,
    output logic                      sel_err,
    input  logic                      err_clr,
    output logic [15:0]               wb_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stateType;

    stateType          state;
    stateType          stateNext;
    logic [DATA_W-1:0] selData;
    logic [DATA_W-1:0] extData;
    logic              selLegal;
    logic              zeroDrop;
    logic              accept;
    logic              enqueue;
    logic              commit;

    // Widen by one bit so NUM_SRC == 2^SEL_W still compares correctly.
    assign selLegal  = ({1'b0, sel} < (SEL_W+1)'(NUM_SRC));
    assign zeroDrop  = (ZERO_SUPPRESS != 0) && (dst_addr == '0);
    assign wb_valid  = (state == FULL);
    assign req_ready = !wb_valid || wb_ready;
    assign accept    = req_valid && req_ready;
    assign enqueue   = accept && selLegal && !zeroDrop;
    assign commit    = wb_valid && wb_ready;

    // Source mux; an out-of-range select yields zero (and is never enqueued).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
        selData = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel == SEL_W'(i)) begin
                selData = src_bus[i*DATA_W +: DATA_W];
            end
        end
    end

    // Load-size extraction, only on the memory-data source.
    always_comb begin
        extData = selData;
        if (sel == SEL_W'(LOAD_SRC)) begin
            case (ld_size)
                2'b10:   extData = {{(DATA_W-8){ld_signed & selData[7]}}, selData[7:0]};
                2'b01:   extData = {{(DATA_W-16){ld_signed & selData[15]}}, selData[15:0]};
                default: extData = selData;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state <= EMPTY;
        end else begin
            state <= stateNext;
        end
    end

    // Next state: fill on a legal accept, drain on a commit not refilled.
    always_comb begin
        stateNext = state;
        case (state)
            EMPTY:   if (enqueue) stateNext = FULL;
            FULL:    if (commit && !enqueue) stateNext = EMPTY;
            default: stateNext = EMPTY;
        endcase
    end

    // Output payload registers; a stalled entry stays frozen.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: the payload is reset because the visible wb_data/wb_addr must read zero after reset.
        if (!reset_n) begin
            wb_data <= '0;
            wb_addr <= '0;
        end else if (enqueue) begin
            wb_data <= extData;
            wb_addr <= dst_addr;
        end
    end

    // Sticky illegal-select flag; a new error wins over a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_err <= 1'b0;
        end else if (accept && !selLegal) begin
            sel_err <= 1'b1;
        end else if (err_clr) begin
            sel_err <= 1'b0;
        end
    end

    // Saturating count of completed writebacks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_count <= '0;
        end else if (commit && (wb_count != 16'hFFFF)) begin
            wb_count <= wb_count + 16'd1;
        end
    end

endmodule

// File: doc/wb_select_stage.md
Name: wb_select_stage

Overview:
- Parametrised, registered successor to the 9-input writeback select mux.
- Sits between datapath sources (RD, SE1_32, MemData, ALUOut, LO, HI, reg227, ...) and the register-file write port.
- Selects one of NUM_SRC sources and applies load-size extraction/extension on the memory-data source.
- Holds the result in a one-entry valid/ready output stage, so the register file can stall writeback.
- Drops and flags illegal selects and $zero writes.

Parameters:
- DATA_W, 32: width of every source and of wb_data.
- NUM_SRC, 9: number of source inputs, 2..16.
- SEL_W, 4: select width; must satisfy 2^SEL_W >= NUM_SRC.
- ADDR_W, 5: register address width.
- LOAD_SRC, 2: source index that receives load-size extraction.
- ZERO_SUPPRESS, 1: when 1, writes to address 0 are dropped.

Ports:
- clk, in, 1: rising-edge clock.
- reset_n, in, 1: asynchronous, active-low reset.
- src_bus, in, NUM_SRC*DATA_W: source i occupies bits [i*DATA_W +: DATA_W].
- sel, in, SEL_W: source select.
- ld_size, in, 2: 00 word, 01 halfword, 10 byte, 11 reserved (treated as word).
- ld_signed, in, 1: 1 sign-extends, 0 zero-extends sub-word loads.
- dst_addr, in, ADDR_W: destination register.
- req_valid, in, 1: request present.
- req_ready, out, 1: stage can accept a request.
- wb_valid, out, 1: writeback pending.
- wb_ready, in, 1: register file accepts the write.
- wb_data, out, DATA_W: registered write data.
- wb_addr, out, ADDR_W: registered write address.
- sel_err, out, 1: sticky illegal-select flag.
- err_clr, in, 1: clears sel_err.
- wb_count, out, 16: saturating count of completed writebacks.

Behaviour:
- Reset (reset_n low, asynchronous): wb_valid=0, wb_data=0, wb_addr=0, sel_err=0, wb_count=0, state=EMPTY.
  - A pending write is discarded; no write is issued after reset.
- State machine: EMPTY (wb_valid=0) and FULL (wb_valid=1).
- req_ready = !wb_valid || wb_ready (combinational). This allows back-to-back throughput of 1 per cycle.
- Accept occurs when req_valid && req_ready.
- Latency: accepted data appears on wb_data/wb_addr with wb_valid=1 on the next rising edge.
- Commit occurs when wb_valid && wb_ready.
  - wb_count increments on each commit and saturates at 16'hFFFF.
- Transitions:
  - EMPTY→FULL on a valid accept.
  - FULL→EMPTY on commit with no valid accept.
  - FULL stays FULL on commit plus a valid accept in the same cycle; new data replaces old.
  - FULL stays FULL with outputs frozen when wb_ready=0; req_ready=0.
- Extraction, applied only when sel==LOAD_SRC. Let s = source value.
  - Byte: bits [7:0], extended per ld_signed to DATA_W.
  - Halfword: bits [15:0], extended per ld_signed.
  - Word or reserved: unchanged.
- Other sources pass unmodified; ld_size and ld_signed are ignored for them.
- Illegal select (sel >= NUM_SRC):
  - The request is accepted (consumed) but not enqueued; state is unchanged by it.
  - sel_err is set on the next edge.
  - A commit of an older entry in the same cycle still proceeds.
- Zero destination (ZERO_SUPPRESS=1 and dst_addr==0):
  - The request is consumed and dropped silently; sel_err is not affected.
- sel_err: set and err_clr in the same cycle leaves sel_err=1 (set wins). err_clr alone clears it on the next edge.
- No combinational path from src_bus, sel or dst_addr to any output.
- req_ready depends only on wb_valid and wb_ready.

Test Plan:
- Reset then select: release reset_n; sel=3, src3=32'h1234_5678, dst=8, req_valid pulsed, wb_ready=1.
  - Expect wb_valid=1 one cycle later with wb_data=32'h1234_5678, wb_addr=8; wb_count=1 after commit.
- Load extraction on source 2 = 32'h0000_80F0:
  - ld_size=10, ld_signed=1 → 32'hFFFF_FFF0.
  - ld_size=01, ld_signed=0 → 32'h0000_80F0.
  - ld_size=01, ld_signed=1 → 32'hFFFF_80F0.
  - Same value on sel=3 passes unchanged for any ld_size.
- Backpressure: wb_ready=0 for 3 cycles with FULL.
  - Expect req_ready=0 and wb_data/wb_addr stable.
  - Raise wb_ready with a new req_valid: commit and new accept in the same cycle; wb_count increments once and the new data appears next edge.
- Illegal and zero drops:
  - sel=9 (NUM_SRC=9): consumed, wb_valid stays 0, sel_err=1.
  - err_clr together with another sel=12: sel_err stays 1; err_clr alone → 0.
  - dst_addr=0: no wb_valid, sel_err unchanged.
- Reset mid-operation: FULL with wb_ready=0, assert reset_n low asynchronously between edges.
  - Expect wb_valid and wb_data to go to 0 immediately, wb_count=0, and no commit after release.
- Saturation and throughput: preload by forcing 65534 commits via a streaming loop with wb_ready=1.
  - Expect 1 commit per cycle and wb_count stopping at 16'hFFFF.
